rom_bus_arbiter: RTL and testbench



---
 rtl/rom_bus_arbiter_if.sv | 39 +++
 rtl/rom_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_rom_bus_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_bus_arbiter_if.sv
// Requester and peripheral-bus signal bundle for rom_bus_arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface rom_bus_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    ack;
  logic               ack_err;
  logic [DW-1:0]      ack_rdata;
  logic               bus_valid;
  logic               bus_we;
  logic [AW-1:0]      bus_addr;
  logic [DW-1:0]      bus_wdata;
  logic [DW-1:0]      bus_rdata;

  modport slave (
    input  req, req_we, req_lock,
    input  req_addr, req_wdata,
    input  bus_rdata,
    output ack, ack_err, ack_rdata,
    output bus_valid, bus_we,
    output bus_addr, bus_wdata
  );

  modport master (
    output req, req_we, req_lock,
    output req_addr, req_wdata,
    output bus_rdata,
    input  ack, ack_err, ack_rdata,
    input  bus_valid, bus_we,
    input  bus_addr, bus_wdata
  );
endinterface

// File: rtl/rom_bus_arbiter.sv
// Round-robin arbiter/sequencer for the peripheral memory bus.
// One access per three cycles: grant, bus cycle, ack.
module rom_bus_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input logic               clk,
  input logic               rst,
  rom_bus_arbiter_if.slave  bus
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t          r_state, w_state_nx;
  logic [PW-1:0]   r_ptr, w_ptr_nx;
  logic [PW-1:0]   r_win, w_win_nx;
  logic            r_lock, w_lock_nx;
  logic            r_ill, w_ill_nx;
  logic            r_bv, w_bv_nx;
  logic            r_bwe, w_bwe_nx;
  logic [AW-1:0]   r_ba, w_ba_nx;
  logic [DW-1:0]   r_bwd, w_bwd_nx;
  logic [NREQ-1:0] r_ack, w_ack_nx;
  logic            r_err, w_err_nx;
  logic [DW-1:0]   r_rd, w_rd_nx;

  logic            w_found;
  logic [PW-1:0]   w_sel;
  int              w_idx;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic            w_sel_we;
  logic            w_ill;

  function automatic logic f_illegal(
    input logic [AW-1:0] a,
    input logic          we
  );
    logic lo, hole, mis, cst, gpr0;
    lo   = a < AW'(32'hffff8000);
    hole = (a >= AW'(32'hffffc200)) &&
           (a <= AW'(32'hffffdfff));
    mis  = a[1:0] != 2'b00;
    cst  = we && (a >= AW'(32'hffffc100)) &&
           (a <= AW'(32'hffffc1ff));
    gpr0 = we && (a == AW'(32'hffffc000));
    return lo | hole | mis | cst | gpr0;
  endfunction

  // Rotating search starting just above the last winner.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && bus.req[PW'(w_idx)]) begin
        w_found = 1'b1;
        w_sel   = PW'(w_idx);
      end
    end
  end

  assign w_sel_addr  = bus.req_addr[int'(w_sel)*AW +: AW];
  assign w_sel_wdata = bus.req_wdata[int'(w_sel)*DW +: DW];
  assign w_sel_we    = bus.req_we[w_sel];
  assign w_ill       = f_illegal(w_sel_addr, w_sel_we);

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_win_nx   = r_win;
    w_lock_nx  = r_lock;
    w_ill_nx   = r_ill;
    w_bv_nx    = 1'b0;
    w_bwe_nx   = 1'b0;
    w_ba_nx    = '0;
    w_bwd_nx   = '0;
    w_ack_nx   = '0;
    w_err_nx   = 1'b0;
    w_rd_nx    = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nx = S_ISSUE;
          w_win_nx   = w_sel;
          w_lock_nx  = bus.req_lock[w_sel];
          w_ill_nx   = w_ill;
          if (!w_ill) begin
            w_bv_nx  = 1'b1;
            w_bwe_nx = w_sel_we;
            w_ba_nx  = w_sel_addr;
            w_bwd_nx = w_sel_wdata;
          end
        end
      end
      S_ISSUE: begin
        w_state_nx = S_RESP;
        w_ack_nx   = NREQ'(1) << r_win;
        w_err_nx   = r_ill;
        if (r_bv && !r_bwe) w_rd_nx = bus.bus_rdata;
      end
      S_RESP: begin
        w_state_nx = S_IDLE;
        // Locked winner parks the pointer just below itself.
        if (!r_lock)
          w_ptr_nx = r_win;
        else if (r_win == '0)
          w_ptr_nx = PW'(NREQ - 1);
        else
          w_ptr_nx = r_win - 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= PW'(NREQ - 1);
      r_win   <= '0;
      r_lock  <= 1'b0;
      r_ill   <= 1'b0;
      r_bv    <= 1'b0;
      r_bwe   <= 1'b0;
      r_ba    <= '0;
      r_bwd   <= '0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_rd    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_win   <= w_win_nx;
      r_lock  <= w_lock_nx;
      r_ill   <= w_ill_nx;
      r_bv    <= w_bv_nx;
      r_bwe   <= w_bwe_nx;
      r_ba    <= w_ba_nx;
      r_bwd   <= w_bwd_nx;
      r_ack   <= w_ack_nx;
      r_err   <= w_err_nx;
      r_rd    <= w_rd_nx;
    end
  end

  assign bus.bus_valid = r_bv;
  assign bus.bus_we    = r_bwe;
  assign bus.bus_addr  = r_ba;
  assign bus.bus_wdata = r_bwd;
  assign bus.ack       = r_ack;
  assign bus.ack_err   = r_err;
  assign bus.ack_rdata = r_rd;
endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Bench for rom_bus_arbiter: frame-queue model, memory device,
// directed phases with literal expectations, then random traffic.
module tb_rom_bus_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rom_bus_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bif();

  rom_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int phase = 0;

  function automatic logic [31:0] defval(input int i);
    if (i == 32'h1000) return 32'h0;
    if (i >= 32'h1040 && i < 32'h1080) return 32'(i - 32'h1040 + 1);
    return 32'h5a5a0000 ^ 32'(i * 32'h9e37);
  endfunction

  function automatic bit illegal(input logic [31:0] a, input bit we);
    if (a < 32'hffff8000) return 1;
    if (a >= 32'hffffc200 && a <= 32'hffffdfff) return 1;
    if (a[1:0] != 2'b00) return 1;
    if (we && a >= 32'hffffc100 && a <= 32'hffffc1ff) return 1;
    if (we && a == 32'hffffc000) return 1;
    return 0;
  endfunction

  // Memory device on the bus
  logic [31:0] dev [8192];
  bit          dwr [8192];
  int          dix;

  always @(posedge clk) begin
    if (bif.bus_valid && bif.bus_we) begin
      dev[bif.bus_addr[14:2]] <= bif.bus_wdata;
      dwr[bif.bus_addr[14:2]] <= 1'b1;
    end
  end

  always_comb begin
    dix = 0;
    dix = int'(bif.bus_addr[14:2]);
    bif.bus_rdata = dwr[dix] ? dev[dix] : defval(dix);
  end

  // Behavioural model: each access is a list of three output frames
  typedef struct {
    logic            bv;
    logic            bwe;
    logic [31:0]     ba;
    logic [31:0]     bwd;
    logic [NREQ-1:0] ack;
    logic            err;
    bit              rd;
    bit              wr;
    logic [31:0]     addr;
    logic [31:0]     wd;
    logic [31:0]     rdata;
  } frame_t;

  frame_t      q[$];
  frame_t      cur = '{default: '0};
  frame_t      zf  = '{default: '0};
  int          mptr = NREQ - 1;
  logic [31:0] refm [8192];
  bit          rwr  [8192];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      cur  = zf;
      mptr = NREQ - 1;
    end else if (q.size() != 0) begin
      cur = q.pop_front();
      if (cur.wr) begin
        refm[cur.addr[14:2]] = cur.wd;
        rwr[cur.addr[14:2]]  = 1'b1;
      end
      if (cur.rd)
        cur.rdata = rwr[cur.addr[14:2]] ? refm[cur.addr[14:2]]
                                        : defval(int'(cur.addr[14:2]));
    end else if (bif.req != '0) begin
      int w;
      bit we, lk, ill;
      logic [31:0] a, wd;
      frame_t f1, f2;
      w = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && bif.req[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
      we  = bif.req_we[w];
      lk  = bif.req_lock[w];
      a   = bif.req_addr[w*AW +: AW];
      wd  = bif.req_wdata[w*DW +: DW];
      ill = illegal(a, we);
      f1 = zf;
      f1.bv  = !ill;
      f1.bwe = !ill && we;
      f1.ba  = ill ? 32'h0 : a;
      f1.bwd = ill ? 32'h0 : wd;
      f2 = zf;
      f2.ack  = NREQ'(1) << w;
      f2.err  = ill;
      f2.rd   = !ill && !we;
      f2.wr   = !ill && we;
      f2.addr = a;
      f2.wd   = wd;
      cur = f1;
      q.push_back(f2);
      q.push_back(zf);
      mptr = lk ? (w + NREQ - 1) % NREQ : w;
    end else begin
      cur = zf;
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit lit(input int ph, input int idx,
                             output logic [NREQ-1:0] ea,
                             output logic ee, output bit crd,
                             output logic [31:0] erd);
    ea = '0; ee = 1'b0; crd = 0; erd = '0;
    case (ph)
      1: if (idx == 0) begin
        ea = 3'b001; crd = 1; erd = 32'h00000002; return 1;
      end
      2: if (idx < 2) begin
        ea = 3'b001; crd = 1;
        erd = (idx == 0) ? 32'h0 : 32'hdeadbeef;
        return 1;
      end
      3: if (idx < 6) begin
        ea = 3'b001 << (idx % 3); return 1;
      end
      4: if (idx < 4) begin
        ea = (idx == 0) ? 3'b001 : 3'b010; return 1;
      end
      5: if (idx < 4) begin
        ea = 3'b001; ee = 1'b1; crd = 1; erd = 32'h0; return 1;
      end
      6: if (idx == 0) begin
        ea = 3'b100; return 1;
      end
      default: ;
    endcase
    return 0;
  endfunction

  int lphase = 0;
  int pidx   = 0;

  always @(negedge clk) begin
    logic [NREQ-1:0] ea;
    logic ee;
    bit crd;
    logic [31:0] erd;
    check("ack",       32'(bif.ack),   32'(cur.ack));
    check("ack_err",   32'(bif.ack_err), 32'(cur.err));
    check("ack_rdata", bif.ack_rdata,  cur.rdata);
    check("bus_valid", 32'(bif.bus_valid), 32'(cur.bv));
    check("bus_we",    32'(bif.bus_we),    32'(cur.bwe));
    check("bus_addr",  bif.bus_addr,   cur.ba);
    check("bus_wdata", bif.bus_wdata,  cur.bwd);
    if (phase != lphase) begin
      lphase = phase;
      pidx   = 0;
    end
    if (phase == 5) check("lit_illegal_bus_valid", 32'(bif.bus_valid), 32'h0);
    if (bif.ack != '0 && phase != 0) begin
      if (lit(phase, pidx, ea, ee, crd, erd)) begin
        check("lit_ack", 32'(bif.ack), 32'(ea));
        check("lit_err", 32'(bif.ack_err), 32'(ee));
        if (crd) check("lit_rdata", bif.ack_rdata, erd);
      end
      pidx++;
    end
  end

  task automatic set_req(input int i, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input bit lk);
    bif.req_we[i]            = we;
    bif.req_lock[i]          = lk;
    bif.req_addr[i*AW +: AW] = a;
    bif.req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    bif.req = '0;
    @(negedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic do_access(input int i, input bit we, input logic [31:0] a,
                           input logic [31:0] wd);
    int n;
    @(negedge clk); #1;
    set_req(i, we, a, wd, 1'b0);
    bif.req[i] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bif.ack[i] && n < 20);
    if (!bif.ack[i]) begin
      $display("FAIL ack_timeout: no ack for requester %0d", i);
      $fatal(1, "timeout");
    end
    #1 bif.req[i] = 1'b0;
  endtask

  task automatic wait_acks(input int cnt, output int got);
    got = 0;
    for (int c = 0; c < 200 && got < cnt; c++) begin
      @(negedge clk);
      if (bif.ack != '0) got++;
    end
    if (got < cnt) begin
      $display("FAIL ack_count_timeout: got %0d acks expected %0d", got, cnt);
      $fatal(1, "timeout");
    end
  endtask

  function automatic logic [31:0] raddr();
    case ($urandom_range(0, 9))
      0: return 32'h00001000 + ($urandom_range(0, 255) << 2);
      1: return 32'hffffc000;
      2: return 32'hffffc004 + ($urandom_range(0, 62) << 2);
      3: return 32'hffffc100 + ($urandom_range(0, 63) << 2);
      4: return 32'hffffc200 + ($urandom_range(0, 1919) << 2);
      5: return 32'hffff8000 + ($urandom_range(0, 4095) << 2);
      6: return 32'hffffe000 + ($urandom_range(0, 2047) << 2);
      7: return 32'hffff8000 + ($urandom_range(0, 8191) << 2)
                + $urandom_range(1, 3);
      default: return 32'hffffc080 + ($urandom_range(0, 7) << 2);
    endcase
  endfunction

  task automatic rand_fields(input int i);
    set_req(i, 1'($urandom_range(0, 1)), raddr(), $urandom,
            $urandom_range(0, 3) == 0);
  endtask

  initial begin
    int got, n;
    logic [NREQ-1:0] aseen;
    bif.req       = '0;
    bif.req_we    = '0;
    bif.req_lock  = '0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    // single read of the constant region
    phase = 1;
    do_access(0, 1'b0, 32'hffffc104, 32'h0);

    // write then read back
    do_reset();
    phase = 2;
    do_access(0, 1'b1, 32'hffffc084, 32'hdeadbeef);
    do_access(0, 1'b0, 32'hffffc084, 32'h0);

    // round robin, all held
    do_reset();
    phase = 3;
    for (int i = 0; i < NREQ; i++)
      set_req(i, 1'b0, 32'hffff8000 + 32'(i * 4), 32'h0, 1'b0);
    bif.req = 3'b111;
    wait_acks(6, got);
    #1 bif.req = '0;

    // lock held by requester 1
    do_reset();
    phase = 4;
    set_req(0, 1'b0, 32'hffffe010, 32'h0, 1'b0);
    set_req(1, 1'b0, 32'hffffe014, 32'h0, 1'b1);
    bif.req = 3'b011;
    wait_acks(4, got);
    #1 bif.req_lock[1] = 1'b0;
    wait_acks(3, got);
    #1 bif.req = '0;

    // illegal accesses
    do_reset();
    phase = 5;
    do_access(0, 1'b1, 32'hffffc100, 32'h11111111);
    do_access(0, 1'b1, 32'hffffc000, 32'h22222222);
    do_access(0, 1'b0, 32'hffffd000, 32'h0);
    do_access(0, 1'b0, 32'hffffc002, 32'h0);
    repeat (2) @(negedge clk);

    // reset during the bus cycle
    do_reset();
    phase = 6;
    @(negedge clk); #1;
    set_req(0, 1'b0, 32'hffffc104, 32'h0, 1'b0);
    bif.req[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bif.bus_valid && n < 10);
    #1;
    rst = 1'b0;
    bif.req = '0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (6) @(negedge clk);
    do_access(2, 1'b0, 32'hffffc108, 32'h0);

    // random traffic
    do_reset();
    phase = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      aseen = bif.ack;
      #1;
      if ($urandom_range(0, 799) == 0) begin
        rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        continue;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bif.req[i] && aseen[i]) begin
          if ($urandom_range(0, 3) == 0) rand_fields(i);
          else bif.req[i] = 1'b0;
        end else if (bif.req[i]) begin
          if ($urandom_range(0, 7) == 0) rand_fields(i);
        end else if ($urandom_range(0, 2) == 0) begin
          rand_fields(i);
          bif.req[i] = 1'b1;
        end
      end
    end
    bif.req = '0;
    repeat (6) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
